// File: rtl/comp_search_pkg.sv
// comp_search_pkg: shared state/cause encodings and a flag helper
// for the comparator search engine and its bench.
package comp_search_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      CHECK  = 3'd2,
      DONE   = 3'd3,
      FAIL   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_FLAGS = 2'b01,
      CAUSE_RANGE = 2'b10
   } cause_t;

   // A well-behaved comparator raises exactly one of eq/lt/gt.
   function automatic logic onehot3(input logic a,
                                    input logic b,
                                    input logic c);
      return ({a, b, c} == 3'b100) ||
             ({a, b, c} == 3'b010) ||
             ({a, b, c} == 3'b001);
   endfunction

endpackage

// File: rtl/comp_search_if.sv
// comp_search_if: start/flag inputs and search status outputs.
// slave = search engine side, master = host/comparator side.
interface comp_search_if #(
   parameter int W = 2
);
   localparam int PW = $clog2(W + 2);

   logic          start;
   logic          F1;
   logic          F2;
   logic          F3;
   logic [W-1:0]  guess;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic [PW-1:0] probes;
   logic          fail;
   logic [1:0]    fail_cause;

   modport slave (
      input  start, F1, F2, F3,
      output guess, busy, done, result,
      output probes, fail, fail_cause
   );

   modport master (
      output start, F1, F2, F3,
      input  guess, busy, done, result,
      input  probes, fail, fail_cause
   );

endinterface

// File: rtl/comp_search.sv
// comp_search: binary-searches a W-bit comparator to recover the
// hidden CD operand. Ports: clk, rst (sync, active-high), bus (slave).
module comp_search
   import comp_search_pkg::*;
#(
   parameter int W             = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input logic        clk,
   input logic        rst,
   comp_search_if.slave bus
);

   localparam int PW = $clog2(W + 2);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [W:0] HI_MAX = {1'b0, {W{1'b1}}};

   state_t        state, state_n;
   cause_t        cause, cause_n;
   logic [W:0]    lo, lo_n;
   logic [W:0]    hi, hi_n;
   logic [W-1:0]  guess, guess_n;
   logic [W-1:0]  result, result_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [PW-1:0] probes, probes_n;

   logic [W:0]    g_ext;
   logic [W:0]    lo_up;
   logic [W:0]    hi_dn;

   assign g_ext = {1'b0, guess};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cause  <= CAUSE_NONE;
         lo     <= '0;
         hi     <= '0;
         guess  <= '0;
         result <= '0;
         cnt    <= '0;
         probes <= '0;
      end else begin
         state  <= state_n;
         cause  <= cause_n;
         lo     <= lo_n;
         hi     <= hi_n;
         guess  <= guess_n;
         result <= result_n;
         cnt    <= cnt_n;
         probes <= probes_n;
      end
   end

   always_comb begin
      state_n  = state;
      cause_n  = cause;
      lo_n     = lo;
      hi_n     = hi;
      guess_n  = guess;
      result_n = result;
      cnt_n    = cnt;
      probes_n = probes;
      lo_up    = '0;
      hi_dn    = '0;

      unique case (state)
         IDLE, DONE, FAIL: begin
            if (bus.start) begin
               lo_n     = '0;
               hi_n     = HI_MAX;
               guess_n  = W'(HI_MAX >> 1);
               probes_n = '0;
               cnt_n    = '0;
               cause_n  = CAUSE_NONE;
               state_n  = SETTLE;
            end
         end

         SETTLE: begin
            if (cnt == CW'(SETTLE_CYCLES - 1)) begin
               state_n = CHECK;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         CHECK: begin
            probes_n = probes + PW'(1);
            cnt_n    = '0;
            if (!onehot3(bus.F1, bus.F2, bus.F3)) begin
               cause_n = CAUSE_FLAGS;
               state_n = FAIL;
            end else if (bus.F1) begin
               result_n = guess;
               state_n  = DONE;
            end else if (bus.F2) begin
               if (g_ext == hi) begin
                  cause_n = CAUSE_RANGE;
                  state_n = FAIL;
               end else begin
                  // Both bounds < 2^W, so the W+1 bit sum cannot wrap.
                  lo_up   = g_ext + (W+1)'(1);
                  lo_n    = lo_up;
                  guess_n = W'((lo_up + hi) >> 1);
                  state_n = SETTLE;
               end
            end else begin
               if (g_ext == lo) begin
                  cause_n = CAUSE_RANGE;
                  state_n = FAIL;
               end else begin
                  // guess > lo >= 0 here, so the decrement is safe.
                  hi_dn   = g_ext - (W+1)'(1);
                  hi_n    = hi_dn;
                  guess_n = W'((lo + hi_dn) >> 1);
                  state_n = SETTLE;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.guess      = guess;
   assign bus.busy       = (state == SETTLE) || (state == CHECK);
   assign bus.done       = (state == DONE);
   assign bus.fail       = (state == FAIL);
   assign bus.result     = result;
   assign bus.probes     = probes;
   assign bus.fail_cause = cause;

endmodule

// File: tb/tb_comp_search.sv
// tb_comp_search: directed bench with a behavioural comparator and
// a queue of expected search outcomes checked on completion.
module tb_comp_search;

   localparam int W  = 2;
   localparam int PW = $clog2(W + 2);

   typedef struct {
      logic        done;
      logic        fail;
      logic [1:0]  cause;
      logic [W-1:0] result;
      logic [PW-1:0] probes;
      int          lat;
      logic [11:0] seq;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [W-1:0] cd = '0;
   int mode = 0;
   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   comp_search_if #(.W(W)) bus ();

   comp_search #(
      .W(W),
      .SETTLE_CYCLES(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Comparator model; mode 1 = F1 and F2 both high,
   // mode 2 = stuck reporting guess < hidden.
   always_comb begin
      bus.F1 = (bus.guess == cd);
      bus.F2 = (bus.guess < cd);
      bus.F3 = (bus.guess > cd);
      if (mode == 1) begin
         bus.F1 = 1'b1;
         bus.F2 = 1'b1;
         bus.F3 = 1'b0;
      end else if (mode == 2) begin
         bus.F1 = 1'b0;
         bus.F2 = 1'b1;
         bus.F3 = 1'b0;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_search(input logic [W-1:0] hid,
                             input int md,
                             input int poke,
                             input exp_t e);
      int cyc;
      logic [11:0] seq;
      logic [W-1:0] last;
      exp_t got;
      cd   = hid;
      mode = md;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_done_low", 32'(bus.done), 32'd0);
      chk("start_fail_low", 32'(bus.fail), 32'd0);
      chk("start_busy", 32'(bus.busy), 32'd1);
      chk("start_probes", 32'(bus.probes), 32'd0);
      seq  = 12'(bus.guess);
      last = bus.guess;
      cyc  = 0;
      while (!(bus.done || bus.fail) && cyc < 50) begin
         @(negedge clk);
         cyc++;
         bus.start = (cyc == poke);
         if (bus.guess != last) begin
            seq  = {seq[9:0], bus.guess};
            last = bus.guess;
         end
      end
      bus.start = 1'b0;
      chk("timeout", 32'(bus.done || bus.fail), 32'd1);
      got = sb.pop_front();
      chk("done", 32'(bus.done), 32'(got.done));
      chk("fail", 32'(bus.fail), 32'(got.fail));
      chk("fail_cause", 32'(bus.fail_cause), 32'(got.cause));
      chk("probes", 32'(bus.probes), 32'(got.probes));
      chk("latency", 32'(cyc), 32'(got.lat));
      chk("guess_seq", 32'(seq), 32'(got.seq));
      chk("busy_end", 32'(bus.busy), 32'd0);
      if (got.done) begin
         chk("result", 32'(bus.result), 32'(got.result));
      end
   endtask

   initial begin
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_guess", 32'(bus.guess), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_probes", 32'(bus.probes), 32'd0);
      chk("rst_fail", 32'(bus.fail), 32'd0);
      chk("rst_cause", 32'(bus.fail_cause), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // CD=3: guesses 1,2,3
      run_search(2'd3, 0, 0, '{1'b1, 1'b0, 2'b00, 2'd3, 2'd3, 6, 12'h01B});
      // CD=0: guesses 1,0 (restart from DONE)
      run_search(2'd0, 0, 0, '{1'b1, 1'b0, 2'b00, 2'd0, 2'd2, 4, 12'h004});
      // CD=1: first probe hits
      run_search(2'd1, 0, 0, '{1'b1, 1'b0, 2'b00, 2'd1, 2'd1, 2, 12'h001});
      // F1 and F2 together: flags not one-hot
      run_search(2'd2, 1, 0, '{1'b0, 1'b1, 2'b01, 2'd0, 2'd1, 2, 12'h001});
      // Stuck F2: range exhausted after 1,2,3
      run_search(2'd0, 2, 0, '{1'b0, 1'b1, 2'b10, 2'd0, 2'd3, 6, 12'h01B});

      // Reset during the second SETTLE of a CD=3 search
      cd   = 2'd3;
      mode = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_guess", 32'(bus.guess), 32'd2);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_guess", 32'(bus.guess), 32'd0);
      chk("mrst_busy", 32'(bus.busy), 32'd0);
      chk("mrst_done", 32'(bus.done), 32'd0);
      chk("mrst_result", 32'(bus.result), 32'd0);
      chk("mrst_probes", 32'(bus.probes), 32'd0);
      chk("mrst_fail", 32'(bus.fail), 32'd0);
      chk("mrst_cause", 32'(bus.fail_cause), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run_search(2'd3, 0, 0, '{1'b1, 1'b0, 2'b00, 2'd3, 2'd3, 6, 12'h01B});

      // start pulse while busy is ignored
      run_search(2'd3, 0, 2, '{1'b1, 1'b0, 2'b00, 2'd3, 2'd3, 6, 12'h01B});
      // restart from DONE with CD=2: guesses 1,2
      run_search(2'd2, 0, 0, '{1'b1, 1'b0, 2'b00, 2'd2, 2'd2, 4, 12'h006});

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
